// File: rtl/mio_pkg.sv
// ---------------------------------------------------------------------------
// mio_pkg
// Shared definitions for the data-side memory/IO bridge:
//   - FSM state encoding (2-bit, legacy-compatible constants)
//   - address-map constants for the IO registers and the RAM region
//   - target-select encoding produced by the address decoder
// ---------------------------------------------------------------------------
package mio_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Address map (word-aligned; byte-offset bits [1:0] are ignored)
    localparam logic [31:0] ADDR_GPIO  = 32'hE000_0000;
    localparam logic [31:0] ADDR_SW    = 32'hF000_0000;
    localparam logic [31:0] ADDR_TIMER = 32'hF000_0004;
    localparam logic [3:0]  RAM_NIBBLE = 4'h0;

    // One-hot target select; exactly one field is set for any address
    typedef struct packed {
        logic is_ram;
        logic is_gpio;
        logic is_sw;
        logic is_timer;
        logic is_unmapped;
    } tgt_sel_t;

endpackage

// File: rtl/mio_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// mio_bus_bridge_if
// CPU MEM-stage data bus between the pipeline and the memory/IO bridge.
//   cpu_req    request strobe, held by the CPU until mio_ready
//   cpu_we     1 = store, 0 = load
//   cpu_addr   byte address
//   cpu_wdata  store data
//   cpu_rdata  load data returned by the bridge
//   mio_ready  one-cycle completion pulse from the bridge
// Modports: master = CPU side, slave = bridge side.
// ---------------------------------------------------------------------------
interface mio_bus_bridge_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        mio_ready;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, mio_ready
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, mio_ready
    );
endinterface

// File: rtl/mio_addr_decode.sv
// ---------------------------------------------------------------------------
// mio_addr_decode
// Combinational address decoder for the memory/IO bridge.
// Ports:
//   addr  in   32-bit byte address (bits [1:0] ignored, word access only)
//   sel   out  one-hot target select {is_ram, is_gpio, is_sw, is_timer,
//              is_unmapped}
// The whole 0x0xxx_xxxx region maps to RAM; the RAM word index is taken
// from the low address bits by the caller, so the region aliases.
// ---------------------------------------------------------------------------
module mio_addr_decode
    import mio_pkg::*;
(
    input  logic [31:0] addr,
    output tgt_sel_t    sel
);

    // Byte-offset bits take no part in the decode
    logic unused_lsb;
    assign unused_lsb = ^addr[1:0];

    always_comb begin
        sel = '0;
        if (addr[31:28] == RAM_NIBBLE) begin
            sel.is_ram = 1'b1;
        end else if (addr[31:2] == ADDR_GPIO[31:2]) begin
            sel.is_gpio = 1'b1;
        end else if (addr[31:2] == ADDR_SW[31:2]) begin
            sel.is_sw = 1'b1;
        end else if (addr[31:2] == ADDR_TIMER[31:2]) begin
            sel.is_timer = 1'b1;
        end else begin
            sel.is_unmapped = 1'b1;
        end
    end

endmodule

// File: rtl/mio_bus_bridge.sv
// ---------------------------------------------------------------------------
// mio_bus_bridge
// Data-side memory/IO bridge sitting right after the CPU's MEM stage.
// Latches one CPU request in IDLE, routes it to the data RAM or to the
// on-chip IO registers (GPIO, switches, free-running timer), and returns
// registered read data with a one-cycle mio_ready pulse.
//
// Parameters:
//   RAM_AW          data RAM word-address width
//   GPIO_W          width of gpio_out (zero-extended on read)
//   UNMAPPED_RDATA  value returned for loads from unmapped addresses
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   bus             CPU bus, slave modport (req/we/addr/wdata in,
//                   rdata/mio_ready out)
//   ram_addr/wdata/we  data RAM request (word address, data, write enable)
//   ram_rdata       RAM read data, valid one cycle after ram_addr
//   sw_in           board switches (already synchronised)
//   gpio_out        LED/GPIO register
//   bus_err         sticky unmapped-access flag
//
// Optional build macro MIO_DEBUG_EN adds:
//   debug_state      current FSM state
//   debug_txn_count  count of completed transactions (wraps)
//
// Latency from the cycle cpu_req is seen in IDLE (cycle 0):
//   RAM load -> mio_ready in cycle 3; everything else -> cycle 2.
// ---------------------------------------------------------------------------
module mio_bus_bridge
    import mio_pkg::*;
#(
    parameter int          RAM_AW         = 10,
    parameter int          GPIO_W         = 16,
    parameter logic [31:0] UNMAPPED_RDATA = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    mio_bus_bridge_if.slave    bus,
    output logic [RAM_AW-1:0]  ram_addr,
    output logic [31:0]        ram_wdata,
    output logic               ram_we,
    input  logic [31:0]        ram_rdata,
    input  logic [15:0]        sw_in,
    output logic [GPIO_W-1:0]  gpio_out,
    output logic               bus_err
`ifdef MIO_DEBUG_EN
    ,
    output logic [1:0]         debug_state,
    output logic [31:0]        debug_txn_count
`endif
);

    logic [1:0]        state_q, state_d;
    logic [31:0]       addr_q,  addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q,    we_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [GPIO_W-1:0] gpio_q,  gpio_d;
    logic [31:0]       timer_q, timer_d;
    logic              err_q,   err_d;

    tgt_sel_t sel;

    // Decode always works on the latched address so the target is stable
    // for the whole transaction, whatever the CPU does with cpu_addr.
    mio_addr_decode u_decode (
        .addr (addr_q),
        .sel  (sel)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        gpio_d  = gpio_q;
        err_d   = err_q;
        // Free-running timer; a CPU write below overrides the increment
        timer_d = timer_q + 32'd1;

        case (state_q)
            ST_IDLE: begin
                // Requests are only accepted here, which guarantees at
                // least one IDLE cycle between back-to-back transactions.
                if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    we_d    = bus.cpu_we;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                state_d = ST_RESP;
                if (sel.is_ram) begin
                    // RAM data arrives a cycle later, so loads detour via
                    // RDWAIT; stores complete with a zero response.
                    if (we_q) begin
                        rdata_d = '0;
                    end else begin
                        state_d = ST_RDWAIT;
                    end
                end else if (sel.is_unmapped) begin
                    err_d   = 1'b1;
                    rdata_d = we_q ? 32'h0 : UNMAPPED_RDATA;
                end else if (we_q) begin
                    // Switch writes fall through here and change nothing
                    rdata_d = '0;
                    if (sel.is_gpio) begin
                        gpio_d = wdata_q[GPIO_W-1:0];
                    end
                    if (sel.is_timer) begin
                        timer_d = wdata_q;
                    end
                end else begin
                    // Timer reads see the value present this cycle, i.e.
                    // before this cycle's increment.
                    if (sel.is_gpio) begin
                        rdata_d = 32'(gpio_q);
                    end else if (sel.is_sw) begin
                        rdata_d = 32'(sw_in);
                    end else begin
                        rdata_d = timer_q;
                    end
                end
            end

            ST_RDWAIT: begin
                rdata_d = ram_rdata;
                state_d = ST_RESP;
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset abandons any transaction in flight; a RAM write already issued
    // in ACCESS is not undone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            gpio_q  <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            gpio_q  <= gpio_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    // RAM address/data simply mirror the latched request, so they hold
    // their values outside ACCESS; only the write enable is qualified.
    assign ram_addr  = addr_q[RAM_AW+1:2];
    assign ram_wdata = wdata_q;
    assign ram_we    = (state_q == ST_ACCESS) && sel.is_ram && we_q;

    assign bus.cpu_rdata = rdata_q;
    assign bus.mio_ready = (state_q == ST_RESP);
    assign gpio_out      = gpio_q;
    assign bus_err       = err_q;

`ifdef MIO_DEBUG_EN
    logic [31:0] txn_cnt_q, txn_cnt_d;

    always_comb begin
        txn_cnt_d = txn_cnt_q;
        if (state_q == ST_RESP) begin
            txn_cnt_d = txn_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txn_cnt_q <= '0;
        end else begin
            txn_cnt_q <= txn_cnt_d;
        end
    end

    assign debug_state     = state_q;
    assign debug_txn_count = txn_cnt_q;
`endif

endmodule

// File: tb/tb_mio_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_mio_bus_bridge
// Scoreboard bench for mio_bus_bridge: the driver issues transactions and
// pushes the expected response (data, completion cycle, bus_err, gpio_out)
// computed by a reference model; a negedge monitor pops and compares on
// every mio_ready and checks every RAM write against expected writes.
// ---------------------------------------------------------------------------
module tb_mio_bus_bridge;
    localparam int RAM_AW = 10;
    localparam int GPIO_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mio_bus_bridge_if bus_if();

    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    logic [15:0]       sw_in;
    logic [GPIO_W-1:0] gpio_out;
    logic              bus_err;
`ifdef MIO_DEBUG_EN
    logic [1:0]        debug_state;
    logic [31:0]       debug_txn_count;
`endif

    mio_bus_bridge #(
        .RAM_AW(RAM_AW), .GPIO_W(GPIO_W), .UNMAPPED_RDATA(32'h0000_0000)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus_if),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .sw_in(sw_in), .gpio_out(gpio_out),
        .bus_err(bus_err)
`ifdef MIO_DEBUG_EN
        , .debug_state(debug_state), .debug_txn_count(debug_txn_count)
`endif
    );

    // Synchronous-read data RAM: data valid one cycle after the address
    logic [31:0] ram_mem [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // Rising-edge counter; at a negedge, pe is the number of the last edge
    int pe = 0;
    always @(posedge clk) pe <= pe + 1;

    int tests = 0;
    int fails = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    typedef struct {
        logic [31:0] rdata;
        int          rdy_at;
        logic        err;
        logic [15:0] gpio;
    } exp_t;
    typedef struct {
        logic [RAM_AW-1:0] a;
        logic [31:0]       d;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wr_q[$];
    logic [31:0] ref_mem [int];
    int          written[$];
    logic [15:0] ref_gpio;
    logic        ref_err;
    logic [31:0] tbase;      // timer value right after edge tkb
    int          tkb;
    int          last_ready = -100;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (bus_if.mio_ready) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_ready: got mio_ready=1, expected no response (edge %0d)", pe);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check32("rsp_rdata", bus_if.cpu_rdata, e.rdata);
                check32("rsp_cycle", 32'(pe), 32'(e.rdy_at));
                check32("rsp_bus_err", {31'h0, bus_err}, {31'h0, e.err});
                check32("rsp_gpio", 32'(gpio_out), 32'(e.gpio));
            end
        end
        if (ram_we) begin
            if (wr_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_ram_we: got ram_we=1 addr 0x%0h, expected ram_we=0", ram_addr);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check32("ram_we_addr", 32'(ram_addr), 32'(w.a));
                check32("ram_we_data", ram_wdata, w.d);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic model_reset();
        tkb      = pe;          // last edge that saw rst high: timer is 0 after it
        tbase    = 32'h0;
        ref_gpio = 16'h0;
        ref_err  = 1'b0;
        last_ready = -100;
    endtask

    // Called at a negedge; returns at the negedge where mio_ready is seen.
    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input int gap);
        int          s;
        int          lat;
        int          idx;
        logic [31:0] wa;
        logic [31:0] r;
        bit          got;
        repeat (gap) @(negedge clk);
        bus_if.cpu_req   = 1'b1;
        bus_if.cpu_we    = we;
        bus_if.cpu_addr  = addr;
        bus_if.cpu_wdata = wdata;
        // Seen at the next edge, but never before the IDLE after a response
        s   = (pe + 1 > last_ready + 2) ? pe + 1 : last_ready + 2;
        idx = int'(addr[RAM_AW+1:2]);
        wa  = {addr[31:2], 2'b00};
        lat = 1;
        r   = 32'h0;
        if (addr[31:28] == 4'h0) begin
            if (we) begin
                ref_mem[idx] = wdata;
                written.push_back(idx);
                wr_q.push_back('{a: addr[RAM_AW+1:2], d: wdata});
            end else begin
                r   = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
                lat = 2;
            end
        end else if (wa == 32'hE000_0000) begin
            if (we) ref_gpio = wdata[15:0];
            else    r = {16'h0, ref_gpio};
        end else if (wa == 32'hF000_0000) begin
            if (!we) r = {16'h0, sw_in};
        end else if (wa == 32'hF000_0004) begin
            if (we) begin
                tbase = wdata;
                tkb   = s + 1;
            end else begin
                r = tbase + 32'(s - tkb);
            end
        end else begin
            ref_err = 1'b1;
        end
        exp_q.push_back('{rdata: r, rdy_at: s + lat, err: ref_err, gpio: ref_gpio});
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus_if.mio_ready) got = 1'b1;
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL ready_timeout: got no mio_ready in 20 cycles, expected one (addr 0x%08h)", addr);
        end
        last_ready = pe;
        bus_if.cpu_req = 1'b0;
    endtask

    task automatic rand_txn();
        int          k;
        int          gap;
        logic [31:0] a;
        k   = $urandom_range(0, 9);
        gap = $urandom_range(0, 3);
        if ($urandom_range(0, 3) == 0) sw_in = 16'($urandom);
        if ((k == 3 || k == 4) && written.size() == 0) k = 0;
        case (k)
            0, 1, 2: begin
                a = ($urandom & 32'h0FFF_F000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
                do_txn(1'b1, a, $urandom, gap);
            end
            3, 4: begin
                a = (32'(written[$urandom_range(0, written.size() - 1)]) << 2) | ($urandom & 32'h0FFF_F003);
                do_txn(1'b0, a, 32'h0, gap);
            end
            5, 9: do_txn(1'($urandom), 32'hE000_0000 | 32'($urandom_range(0, 3)), $urandom, gap);
            6: do_txn(1'($urandom), 32'hF000_0000 | 32'($urandom_range(0, 3)), $urandom, gap);
            7: do_txn(1'($urandom), 32'hF000_0004 | 32'($urandom_range(0, 3)),
                      ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 4)) : $urandom, gap);
            default: begin
                do begin
                    a = $urandom;
                end while (a[31:28] == 4'h0 || a[31:2] == 30'h3800_0000 ||
                           a[31:2] == 30'h3C00_0000 || a[31:2] == 30'h3C00_0001);
                do_txn(1'($urandom), a, $urandom, gap);
            end
        endcase
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_mio_ready"}, {31'h0, bus_if.mio_ready}, 32'h0);
        check32({tag, "_cpu_rdata"}, bus_if.cpu_rdata, 32'h0);
        check32({tag, "_ram_we"},    {31'h0, ram_we}, 32'h0);
        check32({tag, "_ram_addr"},  32'(ram_addr), 32'h0);
        check32({tag, "_ram_wdata"}, ram_wdata, 32'h0);
        check32({tag, "_gpio_out"},  32'(gpio_out), 32'h0);
        check32({tag, "_bus_err"},   {31'h0, bus_err}, 32'h0);
    endtask

    initial begin
        int s;
        bus_if.cpu_req   = 1'b0;
        bus_if.cpu_we    = 1'b0;
        bus_if.cpu_addr  = 32'h0;
        bus_if.cpu_wdata = 32'h0;
        sw_in            = 16'h0;
        rst              = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        model_reset();

        // Free-running timer after reset
        do_txn(1'b0, 32'hF000_0004, 32'h0, 3);

        // RAM store then load
        do_txn(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1);
        do_txn(1'b0, 32'h0000_0010, 32'h0, 1);

        // GPIO write / read
        do_txn(1'b1, 32'hE000_0000, 32'h1234_ABCD, 1);
        check32("gpio_out_after_write", 32'(gpio_out), 32'h0000_ABCD);
        do_txn(1'b0, 32'hE000_0000, 32'h0, 0);

        // Switches: read, and a write that must be ignored
        sw_in = 16'h5A5A;
        do_txn(1'b0, 32'hF000_0000, 32'h0, 1);
        do_txn(1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 1);
        check32("sw_write_no_err", {31'h0, bus_err}, 32'h0);

        // Timer wrap: load near the top, read back once it has wrapped
        do_txn(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 0);
        do_txn(1'b0, 32'hF000_0004, 32'h0, 1);

        // Unmapped load, then check the error stays set
        do_txn(1'b0, 32'h8000_0000, 32'h0, 1);
        repeat (3) @(negedge clk);
        check32("bus_err_sticky", {31'h0, bus_err}, 32'h1);

        for (int i = 0; i < 120; i++) rand_txn();

        // Reset during RDWAIT of a RAM load
        do_txn(1'b1, 32'h0000_0044, 32'h0BAD_BEEF, 1);
        do_txn(1'b1, 32'hE000_0000, 32'h0000_7777, 1);
        do_txn(1'b1, 32'h9000_0000, 32'h0, 1);
        do_txn(1'b0, 32'h0000_0044, 32'h0, 1);
        @(negedge clk);
        bus_if.cpu_req  = 1'b1;
        bus_if.cpu_we   = 1'b0;
        bus_if.cpu_addr = 32'h0000_0044;
        s = pe + 1;
        while (pe < s + 1) @(negedge clk);
        check32("rdwait_no_ready", {31'h0, bus_if.mio_ready}, 32'h0);
        rst = 1'b1;
        bus_if.cpu_req = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        model_reset();
        do_txn(1'b0, 32'h0000_0044, 32'h0, 0);
        do_txn(1'b0, 32'hF000_0004, 32'h0, 2);

        for (int i = 0; i < 120; i++) rand_txn();

        repeat (4) @(negedge clk);
        check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        check32("ram_writes_drained", 32'(wr_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end of test, expected $finish before 2 ms");
        $fatal(1, "timeout");
    end

endmodule
